sbus_mem_slave: RTL and testbench

Responder end of the `sbus` request/stall protocol used by the core's instruction and data buses. It accepts one request at a time from an `sbus` master (`en`, `we`, `size`, `addr`, `data_w`) and holds `stall` high until the access completes. It drives a synchronous word-wide SRAM port with byte strobes and a fixed read latency. One instance serves one bus (ibus or dbus) between the core and on-chip memory.

---
 rtl/sbus_mem_slave_if.sv | 32 +++
 rtl/sbus_mem_slave.sv | 115 +++++++++++
 tb/tb_sbus_mem_slave.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbus_mem_slave_if.sv
// sbus request/stall bundle plus the word-wide SRAM port of one memory slave.
// Latency: none, wires only.
// Backpressure: stall is driven by the slave; the master holds en and the request until stall drops.
// Ports: en/we/size/addr/data_w (request), data_r/stall (response),
//        mem_en/mem_be/mem_addr/mem_wdata (SRAM command), mem_rdata (SRAM read data).
// The master modport is the slave's environment: the core side plus the SRAM.
interface sbus_mem_slave_if #(
    parameter int ADDR_W = 32
);
    logic              en;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data_w;
    logic [31:0]       data_r;
    logic              stall;
    logic              mem_en;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  en, we, size, addr, data_w, mem_rdata,
        output data_r, stall, mem_en, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output en, we, size, addr, data_w, mem_rdata,
        input  data_r, stall, mem_en, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sbus_mem_slave.sv
// sbus responder in front of a synchronous word-wide SRAM with byte strobes.
// Latency: reads MEM_LAT+1 stall cycles, writes and illegal requests 1 stall cycle.
// Backpressure: stall = en & (state != DONE); one access outstanding at most.
// Ports: clk, rst (async, active-low), bus (sbus_mem_slave_if.slave; its ADDR_W
//        must equal this module's ADDR_W).
module sbus_mem_slave #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    sbus_mem_slave_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] data_q, data_nxt;

    logic        legal;
    logic [1:0]  ofs;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic        issue;

    assign ofs = bus.addr[1:0];

    // Misaligned halves/words and size 11 are dropped here; the master raises the exception.
    always_comb begin
        legal = 1'b0;
        case (bus.size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~ofs[0];
            2'b10:   legal = (ofs == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Write data is replicated across lanes so the strobes alone select the bytes.
    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = bus.data_w;
        case (bus.size)
            2'b00: begin
                be_lane    = 4'b0001 << ofs;
                wdata_lane = {4{bus.data_w[7:0]}};
            end
            2'b01: begin
                be_lane    = 4'b0011 << ofs;
                wdata_lane = {2{bus.data_w[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = bus.data_w;
            end
        endcase
    end

    // The SRAM command is only ever issued from IDLE, so a request is sampled exactly once.
    // Gating with rst keeps the SRAM port quiet while reset is held with en high.
    assign issue = rst & (state == S_IDLE) & bus.en & legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            data_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        case (state)
            S_IDLE: begin
                if (bus.en) begin
                    if (!legal) begin
                        data_nxt  = 32'd0;
                        state_nxt = S_DONE;
                    end else if (bus.we) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt   = LAT_M1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            // Runs to completion even if en drops: the read is already in the SRAM pipe.
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    data_nxt  = bus.mem_rdata;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.stall     = bus.en & (state != S_DONE);
    assign bus.data_r    = data_q;
    assign bus.mem_en    = issue;
    assign bus.mem_be    = (issue & bus.we) ? be_lane : 4'b0000;
    assign bus.mem_wdata = (issue & bus.we) ? wdata_lane : 32'd0;
    assign bus.mem_addr  = issue ? bus.addr[ADDR_W-1:2] : '0;
endmodule

// File: tb/tb_sbus_mem_slave.sv
// Bench for sbus_mem_slave: one instance with MEM_LAT=1, one with MEM_LAT=4, each on its own SRAM model.
// Latency: n/a.
// Backpressure: the driver holds each request until stall drops (or abandons it on purpose).
module tb_sbus_mem_slave;
    typedef struct {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        int          lat;
        bit          chk_data;
        logic [31:0] data;
    } cexp_t;

    logic clk;
    logic rst;
    logic sel;
    logic en, we;
    logic [1:0]  size;
    logic [31:0] addr, data_w;

    sbus_mem_slave_if #(.ADDR_W(32)) b1 ();
    sbus_mem_slave_if #(.ADDR_W(32)) b4 ();

    sbus_mem_slave #(.ADDR_W(32), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    sbus_mem_slave #(.ADDR_W(32), .MEM_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    assign b1.en     = en & ~sel;
    assign b4.en     = en & sel;
    assign b1.we     = we;
    assign b4.we     = we;
    assign b1.size   = size;
    assign b4.size   = size;
    assign b1.addr   = addr;
    assign b4.addr   = addr;
    assign b1.data_w = data_w;
    assign b4.data_w = data_w;

    logic        stall_o, mem_en_o;
    logic [3:0]  mem_be_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o, data_r_o;
    assign stall_o     = sel ? b4.stall     : b1.stall;
    assign mem_en_o    = sel ? b4.mem_en    : b1.mem_en;
    assign mem_be_o    = sel ? b4.mem_be    : b1.mem_be;
    assign mem_addr_o  = sel ? b4.mem_addr  : b1.mem_addr;
    assign mem_wdata_o = sel ? b4.mem_wdata : b1.mem_wdata;
    assign data_r_o    = sel ? b4.data_r    : b1.data_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pat(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return {8'(i), 8'hC3, 8'(i * 7 + 1), 8'h5A};
    endfunction

    // SRAM models; read data is poisoned outside its valid cycle to expose mistimed captures.
    logic [31:0] mem1 [64];
    logic [31:0] mem4 [64];
    logic        init1 = 1'b0, init4 = 1'b0;
    logic [31:0] d1;
    logic        v1 = 1'b0;
    logic [31:0] d4 [4];
    logic [3:0]  v4 = 4'b0;

    assign b1.mem_rdata = v1    ? d1    : 32'hBAD0BAD0;
    assign b4.mem_rdata = v4[3] ? d4[3] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (!init1) begin
            for (int i = 0; i < 64; i++) mem1[i] = pat(i);
            init1 <= 1'b1;
        end
        v1 <= 1'b0;
        if (b1.mem_en) begin
            if (b1.mem_be == 4'b0000) begin
                d1 <= mem1[b1.mem_addr[5:0]];
                v1 <= 1'b1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (b1.mem_be[i]) mem1[b1.mem_addr[5:0]][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (!init4) begin
            for (int i = 0; i < 64; i++) mem4[i] = pat(i);
            init4 <= 1'b1;
        end
        for (int i = 3; i > 0; i--) begin
            d4[i] <= d4[i-1];
            v4[i] <= v4[i-1];
        end
        v4[0] <= 1'b0;
        if (b4.mem_en) begin
            if (b4.mem_be == 4'b0000) begin
                d4[0] <= mem4[b4.mem_addr[5:0]];
                v4[0] <= 1'b1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (b4.mem_be[i]) mem4[b4.mem_addr[5:0]][8*i +: 8] <= b4.mem_wdata[8*i +: 8];
            end
        end
    end

    // Scoreboard state
    logic [31:0] ref1 [64];
    logic [31:0] ref4 [64];
    mexp_t mq[$];
    cexp_t cq[$];
    int total = 0;
    int bad   = 0;
    int scnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: checks every SRAM command and every completion against the queues.
    always @(negedge clk) begin
        mexp_t m;
        cexp_t c;
        if (mem_en_o) begin
            if (mq.size() == 0) begin
                chk("spurious_mem_en", 32'd1, 32'd0);
            end else begin
                m = mq.pop_front();
                chk("mem_addr", 32'(mem_addr_o), 32'(m.addr));
                chk("mem_be", 32'(mem_be_o), 32'(m.be));
                chk("mem_wdata", mem_wdata_o, m.wdata);
            end
        end else if (en) begin
            chk("quiet_be", 32'(mem_be_o), 32'd0);
        end
        if (!en) begin
            scnt = 0;
        end else if (stall_o) begin
            scnt++;
        end else begin
            if (cq.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                c = cq.pop_front();
                chk("stall_cycles", 32'(scnt), 32'(c.lat));
                if (c.chk_data) chk("data_r", data_r_o, c.data);
            end
            scnt = 0;
        end
    end

    // Called and returns at posedge+1. ab>0 drops en after ab cycles; rst_hit also pulls reset then.
    task automatic do_req(input bit s4, input bit w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int ab, input bit rst_hit);
        bit          legal;
        bit          done;
        logic [3:0]  be;
        logic [31:0] wd, cur;
        int          idx;
        mexp_t       m;
        cexp_t       c;
        case (sz)
            2'b00:   legal = 1'b1;
            2'b01:   legal = (a[0] == 1'b0);
            2'b10:   legal = (a[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
        case (sz)
            2'b00:   begin be = 4'b0001 << a[1:0]; wd = {4{d[7:0]}}; end
            2'b01:   begin be = 4'b0011 << a[1:0]; wd = {2{d[15:0]}}; end
            default: begin be = 4'b1111; wd = d; end
        endcase
        idx = int'(a[7:2]);
        cur = s4 ? ref4[idx] : ref1[idx];
        if (legal) begin
            m.addr  = a[31:2];
            m.be    = w ? be : 4'b0000;
            m.wdata = w ? wd : 32'd0;
            mq.push_back(m);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
                if (s4) ref4[idx] = cur; else ref1[idx] = cur;
            end
        end
        sel = s4; we = w; size = sz; addr = a; data_w = d; en = 1'b1;
        if (ab > 0) begin
            repeat (ab) @(posedge clk);
            #1;
            if (rst_hit) begin
                rst = 1'b0;
                #1;
                chk("rst_mid_stall", 32'(stall_o), 32'd1);
                chk("rst_mid_mem_en", 32'(mem_en_o), 32'd0);
                chk("rst_mid_mem_addr", 32'(mem_addr_o), 32'd0);
                chk("rst_mid_mem_be", 32'(mem_be_o), 32'd0);
                chk("rst_mid_data_r", data_r_o, 32'd0);
            end
            en = 1'b0;
            #1;
            chk("abandon_stall", 32'(stall_o), 32'd0);
            return;
        end
        c.lat      = (legal && !w) ? (s4 ? 5 : 2) : 1;
        c.chk_data = !(legal && w);
        c.data     = legal ? cur : 32'd0;
        cq.push_back(c);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("completion_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sel = 1'b0; en = 1'b0; we = 1'b0; size = 2'b00; addr = 32'd0; data_w = 32'd0;
        for (int i = 0; i < 64; i++) begin
            ref1[i] = pat(i);
            ref4[i] = pat(i);
        end
        repeat (2) @(posedge clk);
        #1;
        // Reset state with a legal request pending: only stall may follow en.
        en = 1'b1; size = 2'b10; addr = 32'h40; data_w = 32'h1111_2222;
        #1;
        chk("rst_stall", 32'(stall_o), 32'd1);
        chk("rst_mem_en", 32'(mem_en_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_mem_be", 32'(mem_be_o), 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_data_r", data_r_o, 32'd0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // MEM_LAT = 1
        do_req(0, 0, 2'b10, 32'h40, 32'd0, 0, 0);
        do_req(0, 1, 2'b00, 32'h43, 32'h0000_00A5, 0, 0);
        do_req(0, 0, 2'b10, 32'h40, 32'd0, 0, 0);
        do_req(0, 1, 2'b01, 32'h02, 32'h0000_1234, 0, 0);
        do_req(0, 0, 2'b10, 32'h00, 32'd0, 0, 0);
        do_req(0, 0, 2'b10, 32'h41, 32'd0, 0, 0);
        do_req(0, 0, 2'b10, 32'h40, 32'd0, 0, 0);
        do_req(0, 0, 2'b11, 32'h40, 32'd0, 0, 0);
        do_req(0, 0, 2'b10, 32'h44, 32'd0, 0, 0);
        do_req(0, 1, 2'b01, 32'h45, 32'hFFFF_FFFF, 0, 0);
        do_req(0, 1, 2'b10, 32'h48, 32'h0BAD_CAFE, 0, 0);
        do_req(0, 0, 2'b01, 32'h4A, 32'd0, 0, 0);
        for (int n = 0; n < 30; n++)
            do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 255)), $urandom, 0, 0);

        // MEM_LAT = 4
        do_req(1, 0, 2'b10, 32'h40, 32'd0, 0, 0);
        do_req(1, 1, 2'b10, 32'h80, 32'hCAFE_F00D, 0, 0);
        do_req(1, 0, 2'b10, 32'h80, 32'd0, 0, 0);
        // Abandoned read: still captured, FSM back in IDLE five cycles after acceptance.
        do_req(1, 0, 2'b10, 32'h20, 32'd0, 2, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abandon_capture", data_r_o, ref4[8]);
        do_req(1, 0, 2'b01, 32'h22, 32'd0, 0, 0);
        // Reset in WAIT: dropped read, then a fresh access.
        do_req(1, 0, 2'b10, 32'h44, 32'd0, 2, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_req(1, 0, 2'b10, 32'h44, 32'd0, 0, 0);
        for (int n = 0; n < 12; n++)
            do_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   32'($urandom_range(0, 255)), $urandom, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_left", 32'(mq.size()), 32'd0);
        chk("done_q_left", 32'(cq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
